multi_nco: RTL

Parametrised multi-channel numerically controlled oscillator producing CHANNELS independent quadrature (sin/cos) sample streams from a shared quarter-wave lookup table. Each channel has its own run-time programmable frequency tuning word, phase offset and enable. The accumulators advance on a common sample strobe. It replaces the fixed four-channel sin/cos generator at the front of the SDR datapath and feeds the digital mixers.

---
 rtl/multi_nco.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multi_nco.sv
// multi_nco: multi-channel quadrature NCO sharing one quarter-wave sine table.
//
// Each channel owns a phase accumulator, frequency tuning word, phase offset and
// enable. All channels advance together on valid_i. Three-stage pipeline:
//   1. phase = acc + offset (+ dither), truncated to quadrant + table index
//   2. registered table read of L[i] and L[~i]
//   3. registered quadrant sign/select onto sin_o / cos_o
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   valid_i      sample strobe, every channel advances one sample
//   sync_i       phase resync, accumulators restart from 0
//   cfg_we_i     configuration write strobe for channel cfg_ch_i
//   cfg_ch_i     target channel (values >= CHANNELS are ignored)
//   cfg_en_i     enable value written
//   cfg_freq_i   frequency tuning word written
//   cfg_phase_i  phase offset written
//   valid_o      per-channel output valid (valid_i delayed 3 cycles, gated by enable)
//   sin_o/cos_o  signed samples, channel c at [c*OUT_W +: OUT_W]
//
// Build option: define NCO_DITHER_EN to add LFSR phase dither below the
// table resolution; undefined gives plain truncation with no LFSR.

module multi_nco #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned LUT_AW   = 10,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    input  logic                      sync_i,
    input  logic                      cfg_we_i,
    input  logic [CH_W-1:0]           cfg_ch_i,
    input  logic                      cfg_en_i,
    input  logic [PHASE_W-1:0]        cfg_freq_i,
    input  logic [PHASE_W-1:0]        cfg_phase_i,
    output logic [CHANNELS-1:0]       valid_o,
    output logic [CHANNELS*OUT_W-1:0] sin_o,
    output logic [CHANNELS*OUT_W-1:0] cos_o
);

    localparam int unsigned LUT_N = 1 << LUT_AW;
    localparam int unsigned IDX_W = LUT_AW + 2;

    // Quarter-wave table, sampled at half-step offsets so no entry is zero
    // and the two table reads per channel are exact mirror images.
    function automatic logic [OUT_W-1:0] lut_entry(input int unsigned k);
        real amp;
        real x;
        amp = (2.0 ** (OUT_W - 1)) - 1.0;
        x   = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
        return OUT_W'($rtoi(amp * $sin(x) + 0.5));
    endfunction

    logic [OUT_W-1:0] lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = lut_entry(k);
    end

    // Channel state
    logic [PHASE_W-1:0] acc_q  [CHANNELS];
    logic [PHASE_W-1:0] acc_d  [CHANNELS];
    logic [PHASE_W-1:0] acc_base [CHANNELS];
    logic [PHASE_W-1:0] freq_q [CHANNELS];
    logic [PHASE_W-1:0] off_q  [CHANNELS];
    logic [CHANNELS-1:0] en_q;

    // Pipeline state
    logic [IDX_W-1:0]    idx_d    [CHANNELS];
    logic [IDX_W-1:0]    s1_idx_q [CHANNELS];
    logic [CHANNELS-1:0] s1_vld_q;
    logic [LUT_AW-1:0]   rd_i     [CHANNELS];
    logic [LUT_AW-1:0]   rd_ni    [CHANNELS];
    logic [1:0]          s2_quad_q [CHANNELS];
    logic [OUT_W-1:0]    s2_a_q   [CHANNELS];
    logic [OUT_W-1:0]    s2_b_q   [CHANNELS];
    logic [CHANNELS-1:0] s2_vld_q;
    logic [OUT_W-1:0]    sel_sin  [CHANNELS];
    logic [OUT_W-1:0]    sel_cos  [CHANNELS];
    logic [CHANNELS*OUT_W-1:0] sin_q;
    logic [CHANNELS*OUT_W-1:0] cos_q;
    logic [CHANNELS-1:0]       valid_q;

    logic [PHASE_W-1:0] dither;

`ifdef NCO_DITHER_EN
    localparam int DITH_RAW = int'(PHASE_W) - int'(LUT_AW) - 2;
    localparam int DITH_W   = (DITH_RAW > 16) ? 16 : ((DITH_RAW < 1) ? 1 : DITH_RAW);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] lfsr_cur;

    // sync_i reloads the seed, and that seed already dithers the sync sample.
    always_comb begin
        lfsr_cur = sync_i ? LFSR_SEED : lfsr_q;
        lfsr_d   = lfsr_cur;
        if (valid_i) begin
            lfsr_d = {1'b0, lfsr_cur[15:1]} ^ (lfsr_cur[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // No fractional phase bits below the index means nothing to dither.
    assign dither = (DITH_RAW > 0) ? PHASE_W'(lfsr_cur[DITH_W-1:0]) : '0;
`else
    assign dither = '0;
`endif

    // Stage 1: phase and accumulator next state
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            acc_base[c] = sync_i ? '0 : acc_q[c];
            idx_d[c]    = IDX_W'((acc_base[c] + off_q[c] + dither) >> (PHASE_W - IDX_W));
            acc_d[c]    = acc_q[c];
            if (valid_i) begin
                acc_d[c] = acc_base[c] + freq_q[c];
            end else if (sync_i) begin
                acc_d[c] = '0;
            end
        end
    end

    // Stage 3: quadrant select; table entries are positive so negation is safe
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            rd_i[c]  = s1_idx_q[c][LUT_AW-1:0];
            rd_ni[c] = ~s1_idx_q[c][LUT_AW-1:0];
            unique case (s2_quad_q[c])
                2'd0: begin sel_sin[c] =  s2_a_q[c]; sel_cos[c] =  s2_b_q[c]; end
                2'd1: begin sel_sin[c] =  s2_b_q[c]; sel_cos[c] = -s2_a_q[c]; end
                2'd2: begin sel_sin[c] = -s2_a_q[c]; sel_cos[c] = -s2_b_q[c]; end
                default: begin sel_sin[c] = -s2_b_q[c]; sel_cos[c] = s2_a_q[c]; end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= '0;
            s1_vld_q <= '0;
            s2_vld_q <= '0;
            valid_q  <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]     <= '0;
                freq_q[c]    <= '0;
                off_q[c]     <= '0;
                s1_idx_q[c]  <= '0;
                s2_quad_q[c] <= '0;
                s2_a_q[c]    <= '0;
                s2_b_q[c]    <= '0;
            end
        end else begin
            // Enable is sampled with the strobe, so a same-cycle write only
            // affects later samples.
            s1_vld_q <= valid_i ? en_q : '0;
            s2_vld_q <= s1_vld_q;
            valid_q  <= s2_vld_q;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]     <= acc_d[c];
                s1_idx_q[c]  <= idx_d[c];
                s2_quad_q[c] <= s1_idx_q[c][IDX_W-1 -: 2];
                s2_a_q[c]    <= lut[rd_i[c]];
                s2_b_q[c]    <= lut[rd_ni[c]];
                // Disabled channels hold their last sample.
                if (s2_vld_q[c]) begin
                    sin_q[c*OUT_W +: OUT_W] <= sel_sin[c];
                    cos_q[c*OUT_W +: OUT_W] <= sel_cos[c];
                end
                if (cfg_we_i && cfg_ch_i == CH_W'(c)) begin
                    freq_q[c] <= cfg_freq_i;
                    off_q[c]  <= cfg_phase_i;
                    en_q[c]   <= cfg_en_i;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign sin_o   = sin_q;
    assign cos_o   = cos_q;

endmodule
